pacman_game_ctrl: RTL

Top-level game sequencer for the Pacman datapath. Consumes the eat/collision strobes produced inside pacman_game and owns the game state machine: ready delay, play, death, level clear, game over. It also owns the lives and level counters and the remaining-candy count. It gates movement, runs the frightened (power-cookie) timer, and issues position-reset and map-reload strobes to the movement modules and the candy/map BRAM.

---
 rtl/pacman_game_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pacman_game_ctrl.sv
// Game sequencer for the Pacman datapath: ready/play/death/clear/over flow,
// lives, level and candy bookkeeping, and the frightened (power-cookie) timer.
module pacman_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int TOTAL_CANDY  = 244,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int CLEAR_FRAMES = 120,
    parameter int POWER_FRAMES = 360,
    parameter int WARN_FRAMES  = 120
) (
    input  logic                             vga_pix_clk,
    input  logic                             rst,
    input  logic                             frame_stb,
    input  logic                             start,
    input  logic                             ate_candy_stb,
    input  logic                             ate_power_cookie_stb,
    input  logic                             collided_with_enemy,
    output logic [2:0]                       game_state,
    output logic                             move_en,
    output logic                             frightened,
    output logic                             frightened_ending,
    output logic                             ghost_eaten_stb,
    output logic                             pos_reset_stb,
    output logic                             map_reload_stb,
    output logic [3:0]                       lives,
    output logic [7:0]                       level,
    output logic [$clog2(TOTAL_CANDY+1)-1:0] candies_left
);

    localparam int CW   = $clog2(TOTAL_CANDY + 1);
    localparam int EW   = (CW > 2) ? CW : 2;
    localparam int TMAX = (READY_FRAMES > DEATH_FRAMES)
                          ? ((READY_FRAMES > CLEAR_FRAMES) ? READY_FRAMES : CLEAR_FRAMES)
                          : ((DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES);
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam int PW   = (POWER_FRAMES < 1) ? 1 : $clog2(POWER_FRAMES + 1);

    localparam logic [CW-1:0] CANDY_INIT = CW'(TOTAL_CANDY);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [PW-1:0] POWER_INIT = PW'(POWER_FRAMES);
    localparam logic [PW-1:0] WARN_LIM   = PW'(WARN_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] power_q, power_d;
    logic          frightened_q, frightened_d;
    logic          move_en_q, move_en_d;
    logic          ghost_eaten_q, ghost_eaten_d;
    logic          pos_reset_q, pos_reset_d;
    logic          map_reload_q, map_reload_d;
    logic [3:0]    lives_q, lives_d;
    logic [7:0]    level_q, level_d;
    logic [CW-1:0] candies_q, candies_d;
    logic          start_q, coll_q;

    logic          start_rise, coll_rise;
    logic [EW-1:0] eat_n, cand_ext;

    assign start_rise = start & ~start_q;
    assign coll_rise  = collided_with_enemy & ~coll_q;
    assign eat_n      = EW'(ate_candy_stb) + EW'(ate_power_cookie_stb);
    assign cand_ext   = EW'(candies_q);

    // A zero-length phase leaves on the first clock it is in.
    function automatic logic timer_done(input logic [TW-1:0] t, input logic fs, input int n);
        return (n == 0) || (fs && (32'(t) == 32'(n - 1)));
    endfunction

    always_comb begin
        state_d       = state_q;
        power_d       = power_q;
        lives_d       = lives_q;
        level_d       = level_q;
        candies_d     = candies_q;
        ghost_eaten_d = 1'b0;
        pos_reset_d   = 1'b0;
        map_reload_d  = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d      = S_READY;
                    pos_reset_d  = 1'b1;
                    map_reload_d = 1'b1;
                    candies_d    = CANDY_INIT;
                    lives_d      = LIVES_INIT;
                    level_d      = 8'd0;
                end
            end
            S_READY: begin
                if (timer_done(timer_q, frame_stb, READY_FRAMES)) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (cand_ext <= eat_n) begin
                    candies_d = '0;
                end else begin
                    candies_d = CW'(cand_ext - eat_n);
                end
                if (ate_power_cookie_stb) begin
                    power_d = POWER_INIT;
                end else if (frame_stb && (power_q != '0)) begin
                    power_d = power_q - PW'(1);
                end
                ghost_eaten_d = coll_rise && frightened_q;
                // Eating the last edible wins over a simultaneous fatal collision;
                // the registered zero then moves us to CLEAR on the next clock.
                if (candies_q == '0) begin
                    state_d = S_CLEAR;
                end else if (coll_rise && !frightened_q && (candies_d != '0)) begin
                    state_d = S_DYING;
                end
            end
            S_DYING: begin
                if (timer_done(timer_q, frame_stb, DEATH_FRAMES)) begin
                    if (lives_q <= 4'd1) begin
                        lives_d = 4'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d     = lives_q - 4'd1;
                        pos_reset_d = 1'b1;
                        state_d     = S_READY;
                    end
                end
            end
            S_CLEAR: begin
                if (timer_done(timer_q, frame_stb, CLEAR_FRAMES)) begin
                    if (level_q != 8'hFF) begin
                        level_d = level_q + 8'd1;
                    end
                    pos_reset_d  = 1'b1;
                    map_reload_d = 1'b1;
                    candies_d    = CANDY_INIT;
                    state_d      = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Power mode only survives while we stay in PLAY.
        if (state_d != S_PLAY) begin
            power_d = '0;
        end
        frightened_d = (power_d != '0);
        move_en_d    = (state_q == S_PLAY) && (state_d == S_PLAY);
        timer_d      = (state_d != state_q) ? '0 : timer_q + TW'(frame_stb);
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            power_q       <= '0;
            frightened_q  <= 1'b0;
            move_en_q     <= 1'b0;
            ghost_eaten_q <= 1'b0;
            pos_reset_q   <= 1'b0;
            map_reload_q  <= 1'b0;
            lives_q       <= LIVES_INIT;
            level_q       <= 8'd0;
            candies_q     <= CANDY_INIT;
            start_q       <= 1'b1;
            coll_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            power_q       <= power_d;
            frightened_q  <= frightened_d;
            move_en_q     <= move_en_d;
            ghost_eaten_q <= ghost_eaten_d;
            pos_reset_q   <= pos_reset_d;
            map_reload_q  <= map_reload_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            candies_q     <= candies_d;
            start_q       <= start;
            coll_q        <= collided_with_enemy;
        end
    end

    assign game_state        = state_q;
    assign move_en           = move_en_q;
    assign frightened        = frightened_q;
    assign frightened_ending = frightened_q && (power_q <= WARN_LIM);
    assign ghost_eaten_stb   = ghost_eaten_q;
    assign pos_reset_stb     = pos_reset_q;
    assign map_reload_stb    = map_reload_q;
    assign lives             = lives_q;
    assign level             = level_q;
    assign candies_left      = candies_q;

endmodule
